// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage valid/ready register pipeline with bubble collapse.
// Each stage holds a data word and a valid bit. A stage advances whenever any
// stage at or beyond it is empty, or the output is being drained. out_data
// comes straight from the last-stage flop.
module reg_pipe #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int unsigned      OccWidth  = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [OccWidth-1:0] occupancy
);

  logic [WIDTH-1:0]    data_q    [DEPTH];
  logic [WIDTH-1:0]    src_data  [DEPTH];
  logic [DEPTH-1:0]    valid_q;
  logic [DEPTH-1:0]    src_valid;
  logic [DEPTH-1:0]    advance;
  logic [OccWidth-1:0] occ_q;
  logic [OccWidth-1:0] occ_d;
  logic                in_xfer;
  logic                out_xfer;

  // Advance chain: a stage may move if it, or any stage downstream of it, has room.
  always_comb begin
    logic room;
    room    = out_ready;
    advance = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      room       = room | ~valid_q[i];
      advance[i] = room;
    end
  end

  // Load source per stage: the upstream port for stage 0, the previous stage otherwise.
  always_comb begin
    src_valid    = '0;
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      src_valid[i] = valid_q[i-1];
      src_data[i]  = data_q[i-1];
    end
  end

  assign in_ready  = advance[0];
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Next occupancy from the two transfer strobes; both or neither leaves it unchanged.
  always_comb begin
    occ_d = occ_q;
    case ({in_xfer, out_xfer})
      2'b10:   occ_d = occ_q + OccWidth'(1);
      2'b01:   occ_d = occ_q - OccWidth'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Valid bits: advancing stages take the source valid, others hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      valid_q <= (advance & src_valid) | (~advance & valid_q);
    end
  end

  // Data: only real words are loaded, so a passing bubble never disturbs out_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= RESET_VAL;
    end else if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (advance[i] && src_valid[i]) data_q[i] <= src_data[i];
      end
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

endmodule
